// File: rtl/am_argmax_search.sv
// Associative-memory result stage: scans one score per class, reports the argmax
// with a one-cycle strobe alongside the query's latched ground-truth label.
module am_argmax_search #(
    parameter int unsigned NUM_CLASSES_MAX = 32,
    parameter int unsigned CLASS_W         = 5,
    parameter int unsigned SCORE_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CLASS_W:0]   num_classes,
    input  logic [CLASS_W-1:0] correct_class_in,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    output logic               score_ready,
    output logic               busy,
    output logic               tallying_accuracy,
    output logic [CLASS_W-1:0] class_inference,
    output logic [CLASS_W-1:0] correct_class,
    output logic [SCORE_W-1:0] best_score
);
    localparam int unsigned N_W = CLASS_W + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

    state_t             state;
    logic [N_W-1:0]     n_lat;
    logic [CLASS_W-1:0] idx;
    logic [CLASS_W-1:0] run_idx;
    logic [SCORE_W-1:0] run_max;

    logic               accept_c;
    logic               take_c;
    logic               last_c;
    logic [SCORE_W-1:0] nxt_max_c;
    logic [CLASS_W-1:0] nxt_idx_c;
    logic [N_W-1:0]     n_clamp_c;

    // Running-max update for the beat on the bus; strict compare keeps the lower index on ties.
    always_comb begin
        accept_c  = score_valid && score_ready;
        take_c    = (idx == '0) || (score > run_max);
        nxt_max_c = take_c ? score : run_max;
        nxt_idx_c = take_c ? idx : run_idx;
        last_c    = ({1'b0, idx} == (n_lat - N_W'(1)));
        n_clamp_c = (num_classes > N_W'(NUM_CLASSES_MAX)) ? N_W'(NUM_CLASSES_MAX) : num_classes;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            n_lat             <= '0;
            idx               <= '0;
            run_idx           <= '0;
            run_max           <= '0;
            score_ready       <= 1'b0;
            busy              <= 1'b0;
            tallying_accuracy <= 1'b0;
            class_inference   <= '0;
            correct_class     <= '0;
            best_score        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (num_classes != '0)) begin
                        n_lat         <= n_clamp_c;
                        correct_class <= correct_class_in;
                        idx           <= '0;
                        score_ready   <= 1'b1;
                        busy          <= 1'b1;
                        state         <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept_c) begin
                        run_max <= nxt_max_c;
                        run_idx <= nxt_idx_c;
                        idx     <= idx + CLASS_W'(1);
                        // Final beat: publish the result so it is valid alongside the strobe.
                        if (last_c) begin
                            score_ready       <= 1'b0;
                            tallying_accuracy <= 1'b1;
                            class_inference   <= nxt_idx_c;
                            best_score        <= nxt_max_c;
                            state             <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    tallying_accuracy <= 1'b0;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end
                default: begin
                    score_ready       <= 1'b0;
                    busy              <= 1'b0;
                    tallying_accuracy <= 1'b0;
                    state             <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am_argmax_search.sv
// Scoreboard bench for am_argmax_search: expected argmax results are queued when a
// query is driven and compared when the result strobe appears.
module tb_am_argmax_search;
    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  num_classes;
    logic [4:0]  correct_class_in;
    logic        score_valid;
    logic [15:0] score;
    logic        score_ready;
    logic        busy;
    logic        tallying_accuracy;
    logic [4:0]  class_inference;
    logic [4:0]  correct_class;
    logic [15:0] best_score;

    typedef struct {
        int idx;
        int scr;
        int cc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] sc[64];
    int          n_checks;
    int          n_fail;
    int          strobe_count;

    am_argmax_search dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .num_classes       (num_classes),
        .correct_class_in  (correct_class_in),
        .score_valid       (score_valid),
        .score             (score),
        .score_ready       (score_ready),
        .busy              (busy),
        .tallying_accuracy (tallying_accuracy),
        .class_inference   (class_inference),
        .correct_class     (correct_class),
        .best_score        (best_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tallying_accuracy) strobe_count <= strobe_count + 1;
    end

    // Drives one query (start + beats) and queues the reference argmax; returns one
    // time unit after the edge that accepts the final beat.
    task automatic send_query(input int num, input int cc, input bit gaps);
        int   eff;
        exp_t e;
        eff = (num > 32) ? 32 : num;
        e.idx = 0;
        e.scr = int'(sc[0]);
        for (int i = 1; i < eff; i++) begin
            if (int'(sc[i]) > e.scr) begin
                e.scr = int'(sc[i]);
                e.idx = i;
            end
        end
        e.cc = cc;
        exp_q.push_back(e);
        start            = 1'b1;
        num_classes      = 6'(num);
        correct_class_in = 5'(cc);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < eff; i++) begin
            if (gaps) begin
                score_valid = 1'b0;
                score       = 16'hDEAD;
                @(posedge clk); #1;
            end
            score_valid = 1'b1;
            score       = sc[i];
            @(posedge clk); #1;
        end
        score_valid = 1'b0;
        score       = 16'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({score_ready, busy, tallying_accuracy, class_inference, correct_class, best_score} !== 29'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0",
                     {score_ready, busy, tallying_accuracy, class_inference, correct_class, best_score});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        exp_t e;
        int   s0;
        sc[0] = 16'd10; sc[1] = 16'd50; sc[2] = 16'd30; sc[3] = 16'd20;
        s0 = strobe_count;
        send_query(4, 2, 1'b0);
        n_checks++;
        if ({tallying_accuracy, busy, score_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_strobe got tally/busy/ready=%b want 110", {tallying_accuracy, busy, score_ready});
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({class_inference, best_score, correct_class} !== {5'(e.idx), 16'(e.scr), 5'(e.cc)}) begin
            n_fail++;
            $display("FAIL basic_result got idx=%0d best=%0d cc=%0d want idx=%0d best=%0d cc=%0d",
                     class_inference, best_score, correct_class, e.idx, e.scr, e.cc);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({tallying_accuracy, busy, class_inference, best_score} !== {1'b0, 1'b0, 5'd1, 16'd50}) begin
            n_fail++;
            $display("FAIL basic_hold got tally=%b busy=%b idx=%0d best=%0d want 0 0 1 50",
                     tallying_accuracy, busy, class_inference, best_score);
        end
        n_checks++;
        if (strobe_count - s0 !== 1) begin
            n_fail++;
            $display("FAIL basic_pulse_count got %0d want 1", strobe_count - s0);
        end
    endtask

    task automatic test_tie();
        exp_t e;
        sc[0] = 16'd7; sc[1] = 16'd9; sc[2] = 16'd9;
        send_query(3, 0, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if ({tallying_accuracy, class_inference, best_score} !== {1'b1, 5'd1, 16'd9}
            || {class_inference, best_score} !== {5'(e.idx), 16'(e.scr)}) begin
            n_fail++;
            $display("FAIL tie_result got tally=%b idx=%0d best=%0d want 1 1 9",
                     tallying_accuracy, class_inference, best_score);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        exp_t e;
        for (int i = 0; i < 32; i++) sc[i] = 16'h0;
        sc[31] = 16'hFFFF;
        send_query(32, 5, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if ({tallying_accuracy, score_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL gaps_strobe got tally/ready=%b want 10", {tallying_accuracy, score_ready});
        end
        n_checks++;
        if ({class_inference, best_score, correct_class} !== {5'(e.idx), 16'(e.scr), 5'(e.cc)}) begin
            n_fail++;
            $display("FAIL gaps_result got idx=%0d best=%h cc=%0d want idx=%0d best=%h cc=%0d",
                     class_inference, best_score, correct_class, e.idx, e.scr, e.cc);
        end
        score_valid = 1'b1;
        score       = 16'h1234;
        @(posedge clk); #1;
        n_checks++;
        if ({score_ready, busy, best_score} !== {1'b0, 1'b0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL gaps_after got ready=%b busy=%b best=%h want 0 0 ffff", score_ready, busy, best_score);
        end
        score_valid = 1'b0;
    endtask

    task automatic test_zero_start();
        int s0;
        s0 = strobe_count;
        start       = 1'b1;
        num_classes = 6'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if ({busy, score_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL zero_start_idle got busy=%b ready=%b want 0 0", busy, score_ready);
            end
        end
        n_checks++;
        if (strobe_count != s0) begin
            n_fail++;
            $display("FAIL zero_start_strobe got %0d strobes want 0", strobe_count - s0);
        end
    endtask

    task automatic test_clamp();
        exp_t e;
        for (int i = 0; i < 40; i++) sc[i] = 16'($urandom_range(0, 65535));
        sc[35] = 16'hFFFF;
        send_query(40, 7, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (tallying_accuracy !== 1'b1
            || {class_inference, best_score, correct_class} !== {5'(e.idx), 16'(e.scr), 5'(e.cc)}) begin
            n_fail++;
            $display("FAIL clamp_result got tally=%b idx=%0d best=%0d cc=%0d want 1 idx=%0d best=%0d cc=%0d",
                     tallying_accuracy, class_inference, best_score, correct_class, e.idx, e.scr, e.cc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        exp_t e;
        sc[0] = 16'd5;
        send_query(1, 4, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if ({tallying_accuracy, class_inference, best_score, correct_class} !== {1'b1, 5'd0, 16'd5, 5'd4}
            || e.idx != 0) begin
            n_fail++;
            $display("FAIL single_result got tally=%b idx=%0d best=%0d cc=%0d want 1 0 5 4",
                     tallying_accuracy, class_inference, best_score, correct_class);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        exp_t e;
        e.idx = 2; e.scr = 90; e.cc = 3;
        exp_q.push_back(e);
        start = 1'b1; num_classes = 6'd4; correct_class_in = 5'd3;
        @(posedge clk); #1;
        correct_class_in = 5'd9;
        for (int i = 0; i < 4; i++) begin
            start       = (i < 3);
            score_valid = 1'b1;
            score       = (i == 2) ? 16'd90 : 16'(i + 1);
            @(posedge clk); #1;
        end
        start = 1'b0; score_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({tallying_accuracy, class_inference, best_score, correct_class} !== {1'b1, 5'(e.idx), 16'(e.scr), 5'(e.cc)}) begin
            n_fail++;
            $display("FAIL start_ignored got tally=%b idx=%0d best=%0d cc=%0d want 1 2 90 3",
                     tallying_accuracy, class_inference, best_score, correct_class);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   s0;
        s0 = strobe_count;
        sc[0] = 16'd3; sc[1] = 16'd8; sc[2] = 16'd1;
        send_query(3, 11, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if ({tallying_accuracy, class_inference, best_score, correct_class} !== {1'b1, 5'(e.idx), 16'(e.scr), 5'(e.cc)}) begin
            n_fail++;
            $display("FAIL b2b_first got tally=%b idx=%0d best=%0d cc=%0d want 1 %0d %0d %0d",
                     tallying_accuracy, class_inference, best_score, correct_class, e.idx, e.scr, e.cc);
        end
        @(posedge clk); #1;
        sc[0] = 16'd4; sc[1] = 16'd2; sc[2] = 16'd6; sc[3] = 16'd6; sc[4] = 16'd5;
        send_query(5, 20, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if ({tallying_accuracy, class_inference, best_score, correct_class} !== {1'b1, 5'(e.idx), 16'(e.scr), 5'(e.cc)}) begin
            n_fail++;
            $display("FAIL b2b_second got tally=%b idx=%0d best=%0d cc=%0d want 1 %0d %0d %0d",
                     tallying_accuracy, class_inference, best_score, correct_class, e.idx, e.scr, e.cc);
        end
        @(posedge clk); #1;
        n_checks++;
        if (strobe_count - s0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_pulse_count got %0d want 2", strobe_count - s0);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int   s0;
        s0 = strobe_count;
        start = 1'b1; num_classes = 6'd4; correct_class_in = 5'd6;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            score_valid = 1'b1;
            score       = 16'(100 + i);
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({score_ready, busy, tallying_accuracy, class_inference, correct_class, best_score} !== 29'h0) begin
            n_fail++;
            $display("FAIL mid_reset_async got %h want 0",
                     {score_ready, busy, tallying_accuracy, class_inference, correct_class, best_score});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        score_valid = 1'b0;
        n_checks++;
        if (strobe_count != s0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_no_strobe got strobes=%0d busy=%b want 0 0", strobe_count - s0, busy);
        end
        sc[0] = 16'd12; sc[1] = 16'd40; sc[2] = 16'd41; sc[3] = 16'd2;
        send_query(4, 1, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if ({tallying_accuracy, class_inference, best_score, correct_class} !== {1'b1, 5'(e.idx), 16'(e.scr), 5'(e.cc)}) begin
            n_fail++;
            $display("FAIL mid_reset_fresh got tally=%b idx=%0d best=%0d cc=%0d want 1 %0d %0d %0d",
                     tallying_accuracy, class_inference, best_score, correct_class, e.idx, e.scr, e.cc);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        strobe_count = 0;
        rst = 1'b1;
        start = 1'b0;
        num_classes = '0;
        correct_class_in = '0;
        score_valid = 1'b0;
        score = '0;
        test_reset();
        test_basic();
        test_tie();
        test_gaps();
        test_zero_start();
        test_clamp();
        test_single();
        test_start_ignored();
        test_back_to_back();
        test_mid_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/am_argmax_search.md
Name: am_argmax_search

Overview:
- Associative-memory result stage: consumes one similarity score per class and finds the highest-scoring class (argmax).
- Issues a one-cycle result strobe with class_inference and the query's latched correct_class.
- Output port set matches the inputs of the accuracy tally block (tallying_accuracy, correct_class, class_inference), so the two connect directly.

Parameters:
- NUM_CLASSES_MAX, 32, maximum number of classes searched per query
- CLASS_W, 5, class index width; 2**CLASS_W >= NUM_CLASSES_MAX
- SCORE_W, 16, unsigned similarity score width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a query; sampled only in IDLE
- num_classes  in  CLASS_W+1  number of scores for this query; latched on accepted start
- correct_class_in  in  CLASS_W  ground-truth label; latched on accepted start
- score_valid  in  1  score beat valid
- score  in  SCORE_W  unsigned similarity score; beats arrive in class order 0,1,2,...
- score_ready  out  1  block accepts score this cycle
- busy  out  1  high in COLLECT and REPORT
- tallying_accuracy  out  1  one-cycle result strobe
- class_inference  out  CLASS_W  argmax class index; held until the next result
- correct_class  out  CLASS_W  latched label for the current or last query
- best_score  out  SCORE_W  winning score; held until the next result

Behaviour:
- Reset (async, rst=1) applies immediately, any state:
  - state=IDLE
  - score_ready, busy, tallying_accuracy = 0
  - class_inference, correct_class, best_score = 0
  - index counter and running max cleared
  - A reset mid-query abandons the query; no strobe is issued.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE:
  - score_ready=0, busy=0.
  - start=1 with num_classes>=1: latch n = min(num_classes, NUM_CLASSES_MAX); latch correct_class_in into correct_class; idx=0; go to COLLECT.
  - start=1 with num_classes=0: ignored; no state change, no strobe.
- COLLECT:
  - score_ready=1, busy=1.
  - A beat is accepted when score_valid && score_ready; there is no back-pressure inside the block.
  - idx==0: run_max=score, run_idx=0.
  - idx>0: update only if score > run_max (strict, unsigned). Ties keep the lower index.
  - idx increments per accepted beat.
  - When the beat at idx==n-1 is accepted, go to REPORT. Scores arriving after that are not accepted (score_ready=0).
  - score_valid gaps: wait indefinitely, no timeout.
- REPORT (exactly one cycle):
  - tallying_accuracy=1, busy=1, score_ready=0.
  - class_inference=run_idx and best_score=run_max are registered on entry, so they are valid in the same cycle as the strobe.
  - Next cycle: IDLE.
- Latency: strobe asserts the cycle after the final beat is accepted. Minimum query = 1 start cycle + n beat cycles + 1 report cycle.
- start while busy is ignored; it is not queued. Back-to-back: start may be accepted in the cycle after REPORT.
- class_inference, best_score and correct_class hold their values outside REPORT until overwritten.
- Indices use CLASS_W bits, so idx never exceeds NUM_CLASSES_MAX-1. The n clamp guarantees no wrap.

Test Plan:
- Reset, then start with num_classes=4, correct_class_in=2; scores 10,50,30,20 on consecutive cycles -> single tallying_accuracy pulse on the cycle after beat 3; class_inference=1, best_score=50, correct_class=2.
- Tie: num_classes=3, scores 7,9,9 -> class_inference=1 (lower index wins), best_score=9.
- Gaps and extremes: num_classes=32, score_valid toggled every other cycle, score=0xFFFF only at class 31, all others 0 -> class_inference=31; strobe 1 cycle after the 32nd accepted beat; score_ready=0 afterwards.
- Boundary starts:
  - num_classes=0 -> stays IDLE, busy=0, no strobe.
  - num_classes=40 -> clamped to 32; strobe after 32 beats.
  - num_classes=1, score=5 -> class_inference=0 one cycle after the beat.
- start asserted during COLLECT with a different correct_class_in -> ignored; correct_class keeps the original label. Back-to-back queries with start in the cycle after REPORT -> two strobes, each with the correct result.
- Assert rst after 2 of 4 beats -> all outputs 0 immediately with no clk edge; no strobe; a fresh query afterwards gives the correct argmax.
